// File: rtl/wb_fir_bridge.sv
// ---------------------------------------------------------------------------
// wb_fir_bridge
//
// Wishbone slave that fronts a FIR engine. Requests in the 0x30xx_xxxx
// window are decoded on the low 12 address bits:
//   0x000-0x07F  forwarded as one AXI-Lite write (AW then W) or read (AR then R)
//   0x080 write  pushes one sample onto the FIR input stream (ss_*)
//   0x084 read   pops one sample from the FIR output stream (sm_*)
//   other        acknowledged at once with zero read data, no side effect
// Only one transaction is in flight at a time. Stream waits give up after
// pTIMEOUT cycles and return 0xFFFF_FFFF.
//
// Two AXI-Lite writes are also snooped into local shadow state:
//   0x010        data_len, the number of samples in one FIR run
//   0x000 bit0   start, which clears push_cnt
// push_cnt/data_len drive ss_tlast on the final pushed sample.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wbs_*                     Wishbone slave (sel ignored: full words only)
//   aw*/w*/ar*/r*             AXI-Lite master towards the FIR config space
//   ss_t*                     AXI-Stream master, samples into the FIR
//   sm_t*                     AXI-Stream slave, results out of the FIR
//
// Assumes pDATA_WIDTH == 32 so Wishbone data maps one-to-one onto the
// FIR data buses; size casts keep other widths well formed.
// ---------------------------------------------------------------------------
module wb_fir_bridge #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pTIMEOUT    = 1023
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic                   awvalid,
    input  logic                   awready,
    output logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   wvalid,
    input  logic                   wready,
    output logic [pDATA_WIDTH-1:0] wdata,
    output logic                   arvalid,
    input  logic                   arready,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [pDATA_WIDTH-1:0] rdata,
    output logic                   ss_tvalid,
    input  logic                   ss_tready,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   sm_tvalid,
    output logic                   sm_tready,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    input  logic                   sm_tlast
);

    typedef enum logic [2:0] {IDLE, AW, W, AR, R, SS, SM, ACK} state_t;

    localparam int TW = $clog2(pTIMEOUT + 1);

    state_t                 state;
    logic [TW-1:0]          wait_cnt;
    logic [pDATA_WIDTH-1:0] push_cnt;
    logic [pDATA_WIDTH-1:0] data_len;
    logic                   sm_last;

    logic        req;
    logic [11:0] offset;
    logic        is_lite;
    logic        is_push;
    logic        is_pop;
    logic        wait_expired;

    assign req     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == 8'h30);
    assign offset  = wbs_adr_i[11:0];
    assign is_lite = (offset < 12'h080);
    assign is_push = (offset == 12'h080) &  wbs_we_i;
    assign is_pop  = (offset == 12'h084) & ~wbs_we_i;

    // The counter starts at 0 in the first wait cycle, so pTIMEOUT-1 marks
    // the last cycle a handshake is still honoured.
    assign wait_expired = (wait_cnt == TW'(pTIMEOUT - 1));

    // Byte selects, the unused address bits and the captured output-stream
    // tlast have no function in this bridge.
    logic unused_ok;
    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[23:12], sm_last};

    // NOTE: every register below is state, so all assignments are
    // non-blocking; blocking ones would make the result depend on the
    // order in which the simulator evaluates the always blocks.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            push_cnt  <= '0;
            data_len  <= '0;
            sm_last   <= 1'b0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            awvalid   <= 1'b0;
            awaddr    <= '0;
            wvalid    <= 1'b0;
            wdata     <= '0;
            arvalid   <= 1'b0;
            araddr    <= '0;
            rready    <= 1'b0;
            ss_tvalid <= 1'b0;
            ss_tdata  <= '0;
            ss_tlast  <= 1'b0;
            sm_tready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        wbs_dat_o <= '0;
                        wait_cnt  <= '0;
                        if (is_lite && wbs_we_i) begin
                            awaddr  <= pADDR_WIDTH'(offset);
                            wdata   <= pDATA_WIDTH'(wbs_dat_i);
                            awvalid <= 1'b1;
                            state   <= AW;
                        end else if (is_lite) begin
                            araddr  <= pADDR_WIDTH'(offset);
                            arvalid <= 1'b1;
                            state   <= AR;
                        end else if (is_push) begin
                            ss_tdata  <= pDATA_WIDTH'(wbs_dat_i);
                            // data_len of 0 means "unknown length": never flag last.
                            ss_tlast  <= (data_len != '0) &&
                                         (push_cnt == data_len - pDATA_WIDTH'(1));
                            ss_tvalid <= 1'b1;
                            state     <= SS;
                        end else if (is_pop) begin
                            sm_tready <= 1'b1;
                            state     <= SM;
                        end else begin
                            wbs_ack_o <= 1'b1;
                            state     <= ACK;
                        end
                    end
                end

                // Address and data phases are serialised so awvalid and
                // wvalid are never high together.
                AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        state   <= W;
                    end
                end

                W: begin
                    if (wready) begin
                        wvalid    <= 1'b0;
                        wbs_ack_o <= 1'b1;
                        state     <= ACK;
                        // Shadow the FIR config only once the write commits.
                        if (awaddr == pADDR_WIDTH'(12'h010)) begin
                            data_len <= wdata;
                        end
                        if (awaddr == '0 && wdata[0]) begin
                            push_cnt <= '0;
                        end
                    end
                end

                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end

                R: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        wbs_dat_o <= 32'(rdata);
                        wbs_ack_o <= 1'b1;
                        state     <= ACK;
                    end
                end

                // A handshake in the final wait cycle still wins over the timeout.
                SS: begin
                    if (ss_tready) begin
                        ss_tvalid <= 1'b0;
                        ss_tlast  <= 1'b0;
                        push_cnt  <= push_cnt + pDATA_WIDTH'(1);
                        wbs_ack_o <= 1'b1;
                        state     <= ACK;
                    end else if (wait_expired) begin
                        ss_tvalid <= 1'b0;
                        ss_tlast  <= 1'b0;
                        wbs_dat_o <= '1;
                        wbs_ack_o <= 1'b1;
                        state     <= ACK;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end

                SM: begin
                    if (sm_tvalid) begin
                        sm_tready <= 1'b0;
                        wbs_dat_o <= 32'(sm_tdata);
                        sm_last   <= sm_tlast;
                        wbs_ack_o <= 1'b1;
                        state     <= ACK;
                    end else if (wait_expired) begin
                        sm_tready <= 1'b0;
                        wbs_dat_o <= '1;
                        wbs_ack_o <= 1'b1;
                        state     <= ACK;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end

                // One-cycle ack; the master drops stb on this edge, so no new
                // request is taken until the following IDLE cycle.
                ACK: begin
                    wbs_ack_o <= 1'b0;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
